// File: rtl/prbs_pkg.sv
// Shared types and defaults for the PRBS receive checker.
// Latency: n/a (types, constants and a state decode helper only).
// Backpressure: n/a.
package prbs_pkg;

  // FSM encoding; 2'd3 is never written and decodes to HUNT.
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } prbs_state_e;

  localparam int DEF_N        = 32;
  localparam int DEF_LOCK_CNT = 64;
  localparam int DEF_LOSS_WIN = 128;
  localparam int DEF_LOSS_ERR = 8;
  localparam int DEF_CW       = 16;

  // Map a raw state code onto the enum, folding the unused code into HUNT.
  function automatic prbs_state_e prbs_decode(input logic [1:0] code);
    case (code)
      2'd1:    return SYNC;
      2'd2:    return LOCKED;
      default: return HUNT;
    endcase
  endfunction

endpackage

// File: rtl/prbs_loss_window.sv
// Loss-of-lock detector: counts valid bits and mismatches over a sliding block of LOSS_WIN bits.
// Latency: loss is combinational on the offending bit; counters update on the next edge.
// Backpressure: none; en qualifies each bit, counters hold while en is low.
//
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear of both counters
//   en         : a bit is being judged this cycle
//   mis        : that bit mismatched the prediction
//   loss       : this bit is the LOSS_ERR-th error of the current window
module prbs_loss_window
  import prbs_pkg::*;
#(
  parameter int LOSS_WIN = DEF_LOSS_WIN,
  parameter int LOSS_ERR = DEF_LOSS_ERR
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic mis,
  output logic loss
);

  localparam int BW = $clog2(LOSS_WIN + 1);
  localparam int EW = $clog2(LOSS_ERR + 1);

  logic [BW-1:0] r_bits;
  logic [EW-1:0] r_errs;
  logic          w_wrap;

  assign w_wrap = (r_bits == BW'(LOSS_WIN - 1));

  // Judged on the incoming bit, so an error landing on the wrap bit still counts
  // towards the window that is closing.
  assign loss = en & ~clr & mis & (r_errs == EW'(LOSS_ERR - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bits <= '0;
      r_errs <= '0;
    end else if (clr || loss || (en && w_wrap)) begin
      r_bits <= '0;
      r_errs <= '0;
    end else if (en) begin
      r_bits <= r_bits + BW'(1);
      r_errs <= r_errs + EW'(mis);
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: aligns to a Galois LFSR bit stream, then counts bit errors.
// Latency: every output is registered; err / locked change one cycle after the deciding bit.
// Backpressure: none; accepts one bit per clock whenever en is high, holds state otherwise.
//
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   en, bit_i    : received bit and its valid strobe
//   taps         : feedback taps (bit i = x^i term), static while en is active
//   clr          : synchronous restart to HUNT, zeroes err_cnt
//   locked       : FSM in LOCKED
//   err          : one-cycle pulse per mismatch while LOCKED
//   err_cnt      : saturating error count
//   state_o      : raw FSM state
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int LOSS_WIN = DEF_LOSS_WIN,
  parameter int LOSS_ERR = DEF_LOSS_ERR,
  parameter int CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          bit_i,
  input  logic [N-1:0]  taps,
  input  logic          clr,
  output logic          locked,
  output logic          err,
  output logic [CW-1:0] err_cnt,
  output logic [1:0]    state_o
);

  localparam int FW = $clog2(N + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);

  logic [1:0]    r_state;
  logic [N-1:0]  r_hist;     // newest bit at N-1
  logic [FW-1:0] r_fill;
  logic [MW-1:0] r_match;
  logic          r_locked;
  logic          r_err;
  logic [CW-1:0] r_err_cnt;

  prbs_state_e   w_cur;
  prbs_state_e   w_state_nxt;
  logic          w_pred;
  logic          w_mis;
  logic          w_step;
  logic          w_fill_done;
  logic          w_match_done;
  logic          w_loss;
  logic          w_win_en;
  logic          w_win_clr;
  logic          w_err_nxt;
  logic          w_cnt_inc;
  logic          w_locked_nxt;

  assign w_cur        = prbs_decode(r_state);
  assign w_step       = en & ~clr;
  // hist[i] holds s[t+i], so the tap-weighted parity is the recurrence's s[t+N].
  assign w_pred       = ^(taps & r_hist);
  assign w_mis        = w_pred ^ bit_i;
  assign w_fill_done  = (r_fill == FW'(N - 1));
  assign w_match_done = (r_match == MW'(LOCK_CNT - 1));

  // Window counters run only while locked and are held at zero otherwise,
  // which also zeroes them on entry to LOCKED.
  assign w_win_en  = w_step & (w_cur == LOCKED);
  assign w_win_clr = clr | (w_cur != LOCKED);

  prbs_loss_window #(
    .LOSS_WIN (LOSS_WIN),
    .LOSS_ERR (LOSS_ERR)
  ) u_loss_window (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_win_clr),
    .en    (w_win_en),
    .mis   (w_mis),
    .loss  (w_loss)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = w_cur;
    if (clr) begin
      w_state_nxt = HUNT;
    end else if (en) begin
      case (w_cur)
        HUNT:    if (w_fill_done) w_state_nxt = SYNC;
        SYNC:    if (!w_mis && w_match_done) w_state_nxt = LOCKED;
        LOCKED:  if (w_loss) w_state_nxt = HUNT;
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  // FSM: outputs (next values for the output registers)
  always_comb begin
    w_err_nxt    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_locked_nxt = (w_state_nxt == LOCKED);
    if (w_step && (w_cur == LOCKED) && w_mis) begin
      w_err_nxt = 1'b1;
      w_cnt_inc = 1'b1;
    end
  end

  // History and alignment counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= '0;
    end else if (clr) begin
      r_fill  <= '0;
      r_match <= '0;
    end else if (en) begin
      case (w_cur)
        HUNT: begin
          r_hist  <= {bit_i, r_hist[N-1:1]};
          r_fill  <= w_fill_done ? '0 : r_fill + FW'(1);
          r_match <= '0;
        end
        SYNC: begin
          // Shifting the received bit lets a corrupted history flush itself out.
          r_hist  <= {bit_i, r_hist[N-1:1]};
          r_fill  <= '0;
          r_match <= (w_mis || w_match_done) ? '0 : r_match + MW'(1);
        end
        default: begin
          // Flywheel: the prediction, not the line bit, feeds the history so a
          // single line error produces exactly one mismatch.
          r_hist  <= {w_pred, r_hist[N-1:1]};
          r_fill  <= '0;
          r_match <= '0;
        end
      endcase
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_locked <= w_locked_nxt;
      r_err    <= w_err_nxt;
      if (clr) begin
        r_err_cnt <= '0;
      end else if (w_cnt_inc && !(&r_err_cnt)) begin
        r_err_cnt <= r_err_cnt + CW'(1);
      end
    end
  end

  assign locked  = r_locked;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;
  assign state_o = r_state;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: two instances (LOSS_ERR 4 and 31) share one stimulus stream
// from a software Galois LFSR and are compared every cycle against a bit-history model.
// Directed checks pin the lock/loss/error timing of each scenario.
module tb_prbs_checker;

  localparam int N        = 8;
  localparam int LOCK_CNT = 16;
  localparam int LOSS_WIN = 32;
  localparam int CW       = 4;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         bit_i;
  logic [N-1:0] taps_v;
  logic         clr;

  logic          locked0, err0, locked1, err1;
  logic [CW-1:0] cnt0, cnt1;
  logic [1:0]    st0, st1;

  prbs_checker #(
    .N(N), .LOCK_CNT(LOCK_CNT), .LOSS_WIN(LOSS_WIN), .LOSS_ERR(4), .CW(CW)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .bit_i(bit_i), .taps(taps_v), .clr(clr),
    .locked(locked0), .err(err0), .err_cnt(cnt0), .state_o(st0)
  );

  prbs_checker #(
    .N(N), .LOCK_CNT(LOCK_CNT), .LOSS_WIN(LOSS_WIN), .LOSS_ERR(31), .CW(CW)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .bit_i(bit_i), .taps(taps_v), .clr(clr),
    .locked(locked1), .err(err1), .err_cnt(cnt1), .state_o(st1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Software generator: Galois LFSR, output is the MSB before each step.
  logic [N-1:0] g;

  // Reference model: per instance, bits by age (m_last[k][d] = bit received d steps ago).
  int m_loss_err [2] = '{4, 31};
  int m_mode  [2];   // 0 HUNT, 1 SYNC, 2 LOCKED
  int m_fill  [2];
  int m_match [2];
  int m_wb    [2];
  int m_we    [2];
  int m_cnt   [2];
  bit m_err   [2];
  bit m_last  [2][1:N];

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    logic [31:0] expv;
    expv = exp;
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic gen_next(output bit b);
    b = g[N-1];
    g = {g[N-2:0], 1'b0} ^ (b ? taps_v : '0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_fill[k] = 0; m_match[k] = 0;
      m_wb[k] = 0; m_we[k] = 0; m_cnt[k] = 0; m_err[k] = 1'b0;
      for (int d = 1; d <= N; d++) m_last[k][d] = 1'b0;
    end
  endtask

  task automatic push(input int k, input bit v);
    for (int d = N; d >= 2; d--) m_last[k][d] = m_last[k][d-1];
    m_last[k][1] = v;
  endtask

  // One clock edge of the behavioural checker, straight from the recurrence rules.
  task automatic model_step(input bit e, input bit b, input bit c);
    for (int k = 0; k < 2; k++) begin
      bit p;
      bit mis;
      p = 1'b0;
      for (int i = 0; i < N; i++) if (taps_v[i]) p ^= m_last[k][N-i];
      m_err[k] = 1'b0;
      if (c) begin
        m_mode[k] = 0; m_fill[k] = 0; m_match[k] = 0;
        m_wb[k] = 0; m_we[k] = 0; m_cnt[k] = 0;
      end else if (e) begin
        case (m_mode[k])
          0: begin
            push(k, b);
            m_fill[k]++;
            if (m_fill[k] == N) begin m_mode[k] = 1; m_fill[k] = 0; m_match[k] = 0; end
          end
          1: begin
            push(k, b);
            if (b == p) m_match[k]++; else m_match[k] = 0;
            if (m_match[k] == LOCK_CNT) begin m_mode[k] = 2; m_wb[k] = 0; m_we[k] = 0; end
          end
          default: begin
            push(k, p);
            mis = (b != p);
            if (mis) begin
              m_err[k] = 1'b1;
              if (m_cnt[k] < (1 << CW) - 1) m_cnt[k]++;
            end
            m_wb[k]++;
            if (mis) m_we[k]++;
            if (m_we[k] == m_loss_err[k]) begin
              m_mode[k] = 0; m_fill[k] = 0;
            end else if (m_wb[k] == LOSS_WIN) begin
              m_wb[k] = 0; m_we[k] = 0;
            end
          end
        endcase
      end
    end
  endtask

  task automatic cmp_all();
    chk("locked_u0", 32'(locked0), (m_mode[0] == 2) ? 1 : 0);
    chk("err_u0",    32'(err0),    int'(m_err[0]));
    chk("cnt_u0",    32'(cnt0),    m_cnt[0]);
    chk("state_u0",  32'(st0),     m_mode[0]);
    chk("locked_u1", 32'(locked1), (m_mode[1] == 2) ? 1 : 0);
    chk("err_u1",    32'(err1),    int'(m_err[1]));
    chk("cnt_u1",    32'(cnt1),    m_cnt[1]);
    chk("state_u1",  32'(st1),     m_mode[1]);
  endtask

  // Drive one cycle (bit inverted when flip), step the model on the edge, compare #1 later.
  task automatic send(input bit e, input bit flip, input bit c);
    bit b;
    b = 1'b0;
    if (e) begin
      gen_next(b);
      b ^= flip;
      en    = 1'b1;
      bit_i = b;
    end else begin
      en    = 1'b0;
      bit_i = 1'bx;
    end
    clr = c;
    @(posedge clk);
    model_step(e, b, c);
    #1;
    cmp_all();
  endtask

  initial begin
    int pulses0;
    int pulses1;
    int v;
    bit e;

    taps_v = 8'h1D;
    g      = '1;
    rst_n  = 1'b0;
    en     = 1'b0;
    bit_i  = 1'b0;
    clr    = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", 32'(locked0), 0);
    chk("rst_err",    32'(err0),    0);
    chk("rst_cnt",    32'(cnt0),    0);
    chk("rst_state",  32'(st0),     0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean lock: 100 clean bits, lock after the 24th
    pulses0 = 0;
    for (int i = 1; i <= 100; i++) begin
      send(1'b1, 1'b0, 1'b0);
      pulses0 += int'(err0);
      if (i == 23) chk("clean_prelock", 32'(locked0), 0);
      if (i == 24) chk("clean_lock",    32'(locked0), 1);
    end
    chk("clean_pulses", pulses0, 0);
    chk("clean_cnt",    32'(cnt0), 0);

    // Single error on bit 50 after a restart
    send(1'b0, 1'b0, 1'b1);
    pulses0 = 0;
    for (int i = 1; i <= 100; i++) begin
      send(1'b1, i == 50, 1'b0);
      pulses0 += int'(err0);
      if (i == 50) chk("single_pulse_at_50", 32'(err0), 1);
    end
    chk("single_pulses", pulses0, 1);
    chk("single_cnt",    32'(cnt0), 1);
    chk("single_locked", 32'(locked0), 1);

    // Burst: bits 50,52,54,56; 56 is also the window-wrap bit
    send(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 100; i++) begin
      send(1'b1, (i >= 50) && (i <= 56) && (i % 2 == 0), 1'b0);
      if (i == 55) chk("burst_still_locked", 32'(locked0), 1);
      if (i == 56) chk("burst_loss",         32'(locked0), 0);
      if (i == 56) chk("burst_cnt",          32'(cnt0), 4);
      if (i == 79) chk("burst_prerelock",    32'(locked0), 0);
      if (i == 80) chk("burst_relock",       32'(locked0), 1);
    end
    chk("burst_cnt_kept", 32'(cnt0), 4);
    chk("burst_u1_locked", 32'(locked1), 1);

    // Gapped stream, ~30% duty
    send(1'b0, 1'b0, 1'b1);
    v = 0;
    for (int c = 0; c < 600 && v < 60; c++) begin
      e = ($urandom_range(0, 9) < 3);
      send(e, 1'b0, 1'b0);
      if (e) v++;
      if (e && v == 23) chk("gap_prelock", 32'(locked0), 0);
      if (e && v == 24) chk("gap_lock",    32'(locked0), 1);
    end
    chk("gap_cnt", 32'(cnt0), 0);

    // Saturation: 20 isolated errors, LOSS_ERR=31 instance stays locked
    send(1'b0, 1'b0, 1'b1);
    repeat (30) send(1'b1, 1'b0, 1'b0);
    pulses1 = 0;
    for (int i = 0; i < 120; i++) begin
      send(1'b1, (i % 6) == 0, 1'b0);
      pulses1 += int'(err1);
    end
    chk("sat_pulses_u1", pulses1, 20);
    chk("sat_cnt_u1",    32'(cnt1), 15);
    chk("sat_locked_u1", 32'(locked1), 1);

    // Random gaps and random errors, checked by the model alone
    send(1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 600; c++) begin
      send($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3, 1'b0);
    end

    // clr together with an erroneous en bit
    send(1'b0, 1'b0, 1'b1);
    repeat (30) send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    chk("pre_clr_cnt", 32'(cnt0), 1);
    send(1'b1, 1'b1, 1'b1);
    chk("clr_err",   32'(err0), 0);
    chk("clr_cnt",   32'(cnt0), 0);
    chk("clr_state", 32'(st0),  0);
    chk("clr_err_u1", 32'(err1), 0);

    // Asynchronous reset while LOCKED
    repeat (30) send(1'b1, 1'b0, 1'b0);
    chk("prereset_locked", 32'(locked0), 1);
    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    model_reset();
    #1;
    chk("areset_locked", 32'(locked0), 0);
    chk("areset_err",    32'(err0),    0);
    chk("areset_cnt",    32'(cnt1),    0);
    chk("areset_state",  32'(st0),     0);
    chk("areset_cnt0",   32'(cnt0),    0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) send(1'b1, 1'b0, 1'b0);
    chk("post_reset_lock", 32'(locked0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
